audiodac_sample_sched: RTL and testbench

Sample-rate scheduler and source controller for the audio DAC front end. It generates the sample strobe from the system clock, issues single-cycle read pulses to either the sample FIFO or the test sine generator, and registers the selected 16-bit unsigned sample (offset 0x8000) for the modulator. It also mutes cleanly on source switches and tracks FIFO underruns.

---
 rtl/audiodac_pkg.sv | 16 +
 rtl/audiodac_tickgen.sv | 34 +++
 rtl/audiodac_sample_sched.sv | 121 ++++++++++++
 tb/tb_audiodac_sample_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audiodac_pkg.sv
// Shared constants and types for the audio DAC front end.
package audiodac_pkg;

   localparam int unsigned AUDIODAC_SMP_W = 16;
   localparam int unsigned URUN_CNT_W     = 8;

   localparam logic [AUDIODAC_SMP_W-1:0] AUDIODAC_MIDSCALE = 16'h8000;
   localparam logic [URUN_CNT_W-1:0]     URUN_MAX          = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      MUTE = 2'd2
   } audiodac_state_e;

endpackage

// File: rtl/audiodac_tickgen.sv
// Sample-period down-counter: one tick every max(div,1)+1 cycles while enabled.
module audiodac_tickgen #(
   parameter int unsigned DIV_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             start,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick_c
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_eff_c;

   // A divider of zero would give a one-cycle period; clamp it to one.
   assign div_eff_c = (div == '0) ? DIV_W'(1) : div;
   assign tick_c    = en && (cnt == '0);

   // Clear wins, then reload on start or tick, otherwise count down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (start || tick_c) begin
         cnt <= div_eff_c;
      end else if (en) begin
         cnt <= cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/audiodac_sample_sched.sv
// Sample scheduler: source select, mute on switch, underrun tracking.
module audiodac_sample_sched
   import audiodac_pkg::*;
#(
   parameter int unsigned DIV_W    = 10,
   parameter int unsigned MUTE_SMP = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      en_i,
   input  logic [DIV_W-1:0]          div_i,
   input  logic                      tst_sinegen_en_i,
   input  logic [AUDIODAC_SMP_W-1:0] fifo_data_i,
   input  logic                      fifo_empty_i,
   output logic                      fifo_rd_o,
   input  logic [AUDIODAC_SMP_W-1:0] sine_data_i,
   output logic                      sine_rd_o,
   output logic [AUDIODAC_SMP_W-1:0] smp_o,
   output logic                      smp_vld_o,
   output logic                      underrun_o,
   output logic [URUN_CNT_W-1:0]     urun_cnt_o,
   input  logic                      clr_underrun_i
);

   localparam int unsigned MUTE_W = 4;

   audiodac_state_e        state;
   logic                   src_q;
   logic [MUTE_W-1:0]      mute_cnt;
   logic                   tick_c;
   logic                   run_tick_c;
   logic                   urun_evt_c;
   logic [URUN_CNT_W-1:0]  urun_base_c;
   logic [URUN_CNT_W-1:0]  urun_inc_c;

   // Divider runs in RUN and MUTE; leaving enable zeroes it.
   audiodac_tickgen #(
      .DIV_W (DIV_W)
   ) u_tickgen (
      .clk    (clk_i),
      .rst_n  (rst_n_i),
      .en     (state != IDLE),
      .start  ((state == IDLE) && en_i),
      .clr    (!en_i),
      .div    (div_i),
      .tick_c (tick_c)
   );

   // Read strobes decode registered state only, so each lasts one tick cycle.
   assign run_tick_c = (state == RUN) && tick_c;
   assign sine_rd_o  = run_tick_c && src_q;
   assign fifo_rd_o  = run_tick_c && !src_q && !fifo_empty_i;
   assign urun_evt_c = run_tick_c && !src_q && fifo_empty_i;

   // A clear in the same cycle as an underrun restarts the count at one.
   assign urun_base_c = clr_underrun_i ? '0 : urun_cnt_o;
   assign urun_inc_c  = (urun_base_c == URUN_MAX) ? URUN_MAX
                                                  : urun_base_c + URUN_CNT_W'(1);

   // Mode control, sample register and underrun bookkeeping.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         src_q      <= 1'b0;
         mute_cnt   <= '0;
         smp_o      <= AUDIODAC_MIDSCALE;
         smp_vld_o  <= 1'b0;
         underrun_o <= 1'b0;
         urun_cnt_o <= '0;
      end else begin
         smp_vld_o <= 1'b0;
         if (clr_underrun_i) begin
            underrun_o <= 1'b0;
            urun_cnt_o <= '0;
         end
         if (!en_i) begin
            state    <= IDLE;
            smp_o    <= AUDIODAC_MIDSCALE;
            mute_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= RUN;
                  src_q <= tst_sinegen_en_i;
               end
               RUN: begin
                  if (tick_c) begin
                     smp_vld_o <= 1'b1;
                     if (src_q) begin
                        smp_o <= sine_data_i;
                     end else if (!fifo_empty_i) begin
                        smp_o <= fifo_data_i;
                     end
                  end
                  if (urun_evt_c) begin
                     underrun_o <= 1'b1;
                     urun_cnt_o <= urun_inc_c;
                  end
                  if (tst_sinegen_en_i != src_q) begin
                     state    <= MUTE;
                     mute_cnt <= MUTE_W'(MUTE_SMP);
                  end
               end
               MUTE: begin
                  if (tick_c) begin
                     smp_vld_o <= 1'b1;
                     smp_o     <= AUDIODAC_MIDSCALE;
                     mute_cnt  <= mute_cnt - MUTE_W'(1);
                     if (mute_cnt == MUTE_W'(1)) begin
                        state <= RUN;
                        src_q <= tst_sinegen_en_i;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_audiodac_sample_sched.sv
// Testbench for audiodac_sample_sched against a tick-schedule reference model.
module tb_audiodac_sample_sched;

   localparam int unsigned DIV_W    = 10;
   localparam int unsigned MUTE_SMP = 4;
   localparam logic [15:0] MID      = 16'h8000;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic             en_i;
   logic [DIV_W-1:0] div_i;
   logic             tst_sinegen_en_i;
   logic [15:0]      fifo_data_i;
   logic             fifo_empty_i;
   logic             fifo_rd_o;
   logic [15:0]      sine_data_i;
   logic             sine_rd_o;
   logic [15:0]      smp_o;
   logic             smp_vld_o;
   logic             underrun_o;
   logic [7:0]       urun_cnt_o;
   logic             clr_underrun_i;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: mode 0 idle, 1 run, 2 mute; ticks at absolute cycle numbers.
   int          m_mode;
   int          m_next_tick;
   int          m_mute_left;
   int          m_ucnt;
   logic        m_src;
   logic        m_vld;
   logic        m_urun;
   logic [15:0] m_smp;
   logic        e_sine_rd;
   logic        e_fifo_rd;

   always #5 clk_i = ~clk_i;

   audiodac_sample_sched #(
      .DIV_W    (DIV_W),
      .MUTE_SMP (MUTE_SMP)
   ) dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .en_i             (en_i),
      .div_i            (div_i),
      .tst_sinegen_en_i (tst_sinegen_en_i),
      .fifo_data_i      (fifo_data_i),
      .fifo_empty_i     (fifo_empty_i),
      .fifo_rd_o        (fifo_rd_o),
      .sine_data_i      (sine_data_i),
      .sine_rd_o        (sine_rd_o),
      .smp_o            (smp_o),
      .smp_vld_o        (smp_vld_o),
      .underrun_o       (underrun_o),
      .urun_cnt_o       (urun_cnt_o),
      .clr_underrun_i   (clr_underrun_i)
   );

   task automatic model_reset();
      m_mode      = 0;
      m_next_tick = 0;
      m_mute_left = 0;
      m_ucnt      = 0;
      m_src       = 1'b0;
      m_vld       = 1'b0;
      m_urun      = 1'b0;
      m_smp       = MID;
   endtask

   // Current-cycle strobes from the schedule, then next-edge outputs from this cycle's inputs.
   task automatic model_step();
      bit tk;
      int d;
      tk        = (m_mode != 0) && (cyc == m_next_tick);
      e_sine_rd = tk && (m_mode == 1) && m_src;
      e_fifo_rd = tk && (m_mode == 1) && !m_src && !fifo_empty_i;
      d         = (div_i == '0) ? 1 : int'(div_i);
      m_vld     = 1'b0;
      if (clr_underrun_i) begin
         m_urun = 1'b0;
         m_ucnt = 0;
      end
      if (!en_i) begin
         m_mode = 0;
         m_smp  = MID;
      end else if (m_mode == 0) begin
         m_mode      = 1;
         m_src       = tst_sinegen_en_i;
         m_next_tick = cyc + d + 1;
      end else begin
         if (tk) begin
            m_vld       = 1'b1;
            m_next_tick = cyc + d + 1;
         end
         if (m_mode == 1) begin
            if (tk) begin
               if (m_src) m_smp = sine_data_i;
               else if (!fifo_empty_i) m_smp = fifo_data_i;
               else begin
                  m_urun = 1'b1;
                  if (m_ucnt < 255) m_ucnt = m_ucnt + 1;
               end
            end
            if (tst_sinegen_en_i != m_src) begin
               m_mode      = 2;
               m_mute_left = MUTE_SMP;
            end
         end else if (tk) begin
            m_smp       = MID;
            m_mute_left = m_mute_left - 1;
            if (m_mute_left == 0) begin
               m_mode = 1;
               m_src  = tst_sinegen_en_i;
            end
         end
      end
   endtask

   task automatic pre();
      model_step();
      #2;
   endtask

   task automatic post();
      @(posedge clk_i);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (smp_o !== MID) begin n_bad++; $display("FAIL rst_smp got=%h exp=%h", smp_o, MID); end
      n_cmp++; if (smp_vld_o !== 1'b0) begin n_bad++; $display("FAIL rst_vld got=%b exp=0", smp_vld_o); end
      n_cmp++; if (fifo_rd_o !== 1'b0) begin n_bad++; $display("FAIL rst_fifo_rd got=%b exp=0", fifo_rd_o); end
      n_cmp++; if (sine_rd_o !== 1'b0) begin n_bad++; $display("FAIL rst_sine_rd got=%b exp=0", sine_rd_o); end
      n_cmp++; if (underrun_o !== 1'b0) begin n_bad++; $display("FAIL rst_urun got=%b exp=0", underrun_o); end
      n_cmp++; if (urun_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rst_ucnt got=%0d exp=0", urun_cnt_o); end
      rst_n_i = 1'b1;
      model_reset();
      pre();
      post();
      n_cmp++; if (smp_o !== MID) begin n_bad++; $display("FAIL rst_idle_smp got=%h exp=%h", smp_o, MID); end
      n_cmp++; if (smp_vld_o !== 1'b0) begin n_bad++; $display("FAIL rst_idle_vld got=%b exp=0", smp_vld_o); end
   endtask

   task automatic test_sine();
      int first;
      first = -1;
      div_i = DIV_W'(3); tst_sinegen_en_i = 1'b1; en_i = 1'b1;
      for (int i = 0; i < 26; i++) begin
         sine_data_i = 16'($urandom);
         pre();
         n_cmp++; if (sine_rd_o !== e_sine_rd) begin n_bad++; $display("FAIL sine_rd cyc=%0d got=%b exp=%b", cyc, sine_rd_o, e_sine_rd); end
         n_cmp++; if (fifo_rd_o !== 1'b0) begin n_bad++; $display("FAIL sine_fifo_rd cyc=%0d got=%b exp=0", cyc, fifo_rd_o); end
         if (sine_rd_o && first < 0) first = i;
         post();
         n_cmp++; if (smp_vld_o !== m_vld) begin n_bad++; $display("FAIL sine_vld cyc=%0d got=%b exp=%b", cyc, smp_vld_o, m_vld); end
         n_cmp++; if (smp_o !== m_smp) begin n_bad++; $display("FAIL sine_smp cyc=%0d got=%h exp=%h", cyc, smp_o, m_smp); end
      end
      n_cmp++; if (first != 4) begin n_bad++; $display("FAIL sine_first_pulse got=%0d exp=4", first); end
   endtask

   task automatic test_underrun();
      logic [15:0] last_word;
      last_word = '0;
      en_i = 1'b0; pre(); post();
      tst_sinegen_en_i = 1'b0; div_i = '0; fifo_empty_i = 1'b0; clr_underrun_i = 1'b0; en_i = 1'b1;
      for (int i = 0; i < 616; i++) begin
         fifo_data_i    = 16'($urandom);
         fifo_empty_i   = (i >= 8);
         clr_underrun_i = (i == 611) || (i == 614);
         if (i == 6) last_word = fifo_data_i;
         pre();
         n_cmp++; if (fifo_rd_o !== e_fifo_rd) begin n_bad++; $display("FAIL ur_fifo_rd cyc=%0d got=%b exp=%b", cyc, fifo_rd_o, e_fifo_rd); end
         if (i == 8) begin
            n_cmp++; if (fifo_rd_o !== 1'b0) begin n_bad++; $display("FAIL ur_no_pop got=%b exp=0", fifo_rd_o); end
         end
         post();
         n_cmp++; if (smp_o !== m_smp) begin n_bad++; $display("FAIL ur_smp cyc=%0d got=%h exp=%h", cyc, smp_o, m_smp); end
         n_cmp++; if (smp_vld_o !== m_vld) begin n_bad++; $display("FAIL ur_vld cyc=%0d got=%b exp=%b", cyc, smp_vld_o, m_vld); end
         n_cmp++; if (underrun_o !== m_urun) begin n_bad++; $display("FAIL ur_flag cyc=%0d got=%b exp=%b", cyc, underrun_o, m_urun); end
         n_cmp++; if (urun_cnt_o !== 8'(m_ucnt)) begin n_bad++; $display("FAIL ur_cnt cyc=%0d got=%0d exp=%0d", cyc, urun_cnt_o, m_ucnt); end
         if (i == 8) begin
            n_cmp++; if (smp_o !== last_word) begin n_bad++; $display("FAIL ur_hold got=%h exp=%h", smp_o, last_word); end
            n_cmp++; if (underrun_o !== 1'b1 || urun_cnt_o !== 8'd1) begin n_bad++; $display("FAIL ur_first got=%b/%0d exp=1/1", underrun_o, urun_cnt_o); end
         end
         if (i == 609) begin
            n_cmp++; if (urun_cnt_o !== 8'd255) begin n_bad++; $display("FAIL ur_sat got=%0d exp=255", urun_cnt_o); end
         end
         if (i == 611) begin
            n_cmp++; if (underrun_o !== 1'b0 || urun_cnt_o !== 8'd0) begin n_bad++; $display("FAIL ur_clear got=%b/%0d exp=0/0", underrun_o, urun_cnt_o); end
         end
         if (i == 614) begin
            n_cmp++; if (underrun_o !== 1'b1 || urun_cnt_o !== 8'd1) begin n_bad++; $display("FAIL ur_clr_vs_new got=%b/%0d exp=1/1", underrun_o, urun_cnt_o); end
         end
      end
      clr_underrun_i = 1'b0; fifo_empty_i = 1'b0;
   endtask

   task automatic test_mute_and_reset();
      int first_sine;
      int mute_vld;
      int mute_rd;
      int first_fifo;
      first_sine = -1; mute_vld = 0; mute_rd = 0; first_fifo = -1;
      en_i = 1'b0; pre(); post();
      tst_sinegen_en_i = 1'b0; div_i = DIV_W'(2); fifo_empty_i = 1'b0; en_i = 1'b1;
      for (int i = 0; i < 36; i++) begin
         fifo_data_i = 16'($urandom);
         sine_data_i = 16'($urandom);
         if (i == 10 || i == 17) tst_sinegen_en_i = 1'b1;
         if (i == 16 || i == 30) tst_sinegen_en_i = 1'b0;
         pre();
         n_cmp++; if (sine_rd_o !== e_sine_rd) begin n_bad++; $display("FAIL mute_sine_rd cyc=%0d got=%b exp=%b", cyc, sine_rd_o, e_sine_rd); end
         n_cmp++; if (fifo_rd_o !== e_fifo_rd) begin n_bad++; $display("FAIL mute_fifo_rd cyc=%0d got=%b exp=%b", cyc, fifo_rd_o, e_fifo_rd); end
         if (i > 10 && i < 24 && (sine_rd_o || fifo_rd_o)) mute_rd++;
         if (i > 10 && sine_rd_o && first_sine < 0) first_sine = i;
         post();
         n_cmp++; if (smp_vld_o !== m_vld) begin n_bad++; $display("FAIL mute_vld cyc=%0d got=%b exp=%b", cyc, smp_vld_o, m_vld); end
         n_cmp++; if (smp_o !== m_smp) begin n_bad++; $display("FAIL mute_smp cyc=%0d got=%h exp=%h", cyc, smp_o, m_smp); end
         if (i >= 10 && i <= 23 && smp_vld_o && smp_o === MID) mute_vld++;
      end
      n_cmp++; if (mute_vld != 4) begin n_bad++; $display("FAIL mute_ticks got=%0d exp=4", mute_vld); end
      n_cmp++; if (mute_rd != 0) begin n_bad++; $display("FAIL mute_rd_pulses got=%0d exp=0", mute_rd); end
      n_cmp++; if (first_sine != 24) begin n_bad++; $display("FAIL mute_exit_tick got=%0d exp=24", first_sine); end
      // Asynchronous reset while muted.
      rst_n_i = 1'b0;
      #1;
      n_cmp++; if (smp_o !== MID) begin n_bad++; $display("FAIL arst_smp got=%h exp=%h", smp_o, MID); end
      n_cmp++; if (smp_vld_o !== 1'b0) begin n_bad++; $display("FAIL arst_vld got=%b exp=0", smp_vld_o); end
      n_cmp++; if (sine_rd_o !== 1'b0 || fifo_rd_o !== 1'b0) begin n_bad++; $display("FAIL arst_rd got=%b%b exp=00", sine_rd_o, fifo_rd_o); end
      n_cmp++; if (underrun_o !== 1'b0 || urun_cnt_o !== 8'd0) begin n_bad++; $display("FAIL arst_urun got=%b/%0d exp=0/0", underrun_o, urun_cnt_o); end
      #2;
      rst_n_i = 1'b1;
      model_reset();
      tst_sinegen_en_i = 1'b0; div_i = DIV_W'(3); fifo_empty_i = 1'b0; en_i = 1'b1;
      for (int j = 0; j < 13; j++) begin
         fifo_data_i = 16'($urandom);
         sine_data_i = 16'($urandom);
         pre();
         n_cmp++; if (fifo_rd_o !== e_fifo_rd || sine_rd_o !== e_sine_rd) begin n_bad++; $display("FAIL post_rst_rd cyc=%0d got=%b%b exp=%b%b", cyc, fifo_rd_o, sine_rd_o, e_fifo_rd, e_sine_rd); end
         if (fifo_rd_o && first_fifo < 0) first_fifo = j;
         post();
         n_cmp++; if (smp_o !== m_smp || smp_vld_o !== m_vld) begin n_bad++; $display("FAIL post_rst_smp cyc=%0d got=%h/%b exp=%h/%b", cyc, smp_o, smp_vld_o, m_smp, m_vld); end
      end
      n_cmp++; if (first_fifo != 4) begin n_bad++; $display("FAIL post_rst_first got=%0d exp=4", first_fifo); end
   endtask

   task automatic test_en_drop();
      int drop;
      int pulses;
      drop = -1; pulses = 0;
      en_i = 1'b0; pre(); post();
      tst_sinegen_en_i = 1'b1; div_i = DIV_W'(3); en_i = 1'b1;
      for (int i = 0; i < 30; i++) begin
         sine_data_i = 16'($urandom);
         if (drop < 0 && i > 5 && m_mode == 1 && cyc == m_next_tick - 1) begin
            en_i = 1'b0;
            drop = i;
         end else if (drop >= 0 && i == drop + 1) begin
            en_i  = 1'b1;
            div_i = '0;
         end
         pre();
         n_cmp++; if (sine_rd_o !== e_sine_rd) begin n_bad++; $display("FAIL drop_sine_rd cyc=%0d got=%b exp=%b", cyc, sine_rd_o, e_sine_rd); end
         if (drop >= 0 && i == drop + 1) begin
            n_cmp++; if (sine_rd_o !== 1'b0) begin n_bad++; $display("FAIL drop_no_rd got=%b exp=0", sine_rd_o); end
         end
         if (drop >= 0 && i > drop + 1 && i <= drop + 13 && sine_rd_o) pulses++;
         post();
         n_cmp++; if (smp_o !== m_smp || smp_vld_o !== m_vld) begin n_bad++; $display("FAIL drop_smp cyc=%0d got=%h/%b exp=%h/%b", cyc, smp_o, smp_vld_o, m_smp, m_vld); end
         if (drop >= 0 && i == drop) begin
            n_cmp++; if (smp_o !== MID) begin n_bad++; $display("FAIL drop_mid got=%h exp=%h", smp_o, MID); end
         end
      end
      n_cmp++; if (pulses != 6) begin n_bad++; $display("FAIL drop_period2 got=%0d exp=6", pulses); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         en_i           = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 49) == 0) tst_sinegen_en_i = ~tst_sinegen_en_i;
         div_i          = DIV_W'($urandom_range(0, 5));
         fifo_empty_i   = ($urandom_range(0, 3) == 0);
         clr_underrun_i = ($urandom_range(0, 49) == 0);
         fifo_data_i    = 16'($urandom);
         sine_data_i    = 16'($urandom);
         pre();
         n_cmp++; if (sine_rd_o !== e_sine_rd || fifo_rd_o !== e_fifo_rd) begin n_bad++; $display("FAIL rnd_rd cyc=%0d got=%b%b exp=%b%b", cyc, sine_rd_o, fifo_rd_o, e_sine_rd, e_fifo_rd); end
         post();
         n_cmp++; if (smp_o !== m_smp) begin n_bad++; $display("FAIL rnd_smp cyc=%0d got=%h exp=%h", cyc, smp_o, m_smp); end
         n_cmp++; if (smp_vld_o !== m_vld) begin n_bad++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, smp_vld_o, m_vld); end
         n_cmp++; if (underrun_o !== m_urun || urun_cnt_o !== 8'(m_ucnt)) begin n_bad++; $display("FAIL rnd_urun cyc=%0d got=%b/%0d exp=%b/%0d", cyc, underrun_o, urun_cnt_o, m_urun, m_ucnt); end
      end
   endtask

   initial begin
      rst_n_i          = 1'b0;
      en_i             = 1'b0;
      div_i            = '0;
      tst_sinegen_en_i = 1'b0;
      fifo_data_i      = '0;
      fifo_empty_i     = 1'b1;
      sine_data_i      = '0;
      clr_underrun_i   = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_i);
      test_reset();
      test_sine();
      test_underrun();
      test_mute_and_reset();
      test_en_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
